// File: rtl/rom_dump_sequencer.sv
// rom_dump_sequencer
// Walks an entire ROM through rom_reader's address-step inputs, from address 0
// to the last address. At each address it waits for rom_reader to report the
// expected address, lets the data settle, and offers an {address, data} word
// on a valid/ready stream. All outputs are registered and follow the state
// that is being entered, so each output is a clean function of the state.

module rom_dump_sequencer #(
    parameter int DATA_WIDTH        = 4,
    parameter int ADDRESS_WIDTH     = 8,
    parameter int STEP_PULSE_CYCLES = 8,
    parameter int SETTLE_CYCLES     = 16,
    parameter int ACK_TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic                     reader_reset_n,
    output logic                     increment_address,
    output logic                     decrement_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    // One shared timer serves the reader-reset, settle, step and ack phases;
    // it must be wide enough for the longest of them.
    localparam int TIMER_MAX_A = (STEP_PULSE_CYCLES > SETTLE_CYCLES) ? STEP_PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_MAX   = (TIMER_MAX_A > ACK_TIMEOUT) ? TIMER_MAX_A : ACK_TIMEOUT;
    localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO  = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);
    // rom_reader is held in reset for two cycles: timer values 0 and 1.
    localparam logic [TIMER_WIDTH-1:0] RST_LAST    = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] STEP_LAST   = TIMER_WIDTH'(STEP_PULSE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] ACK_LAST    = TIMER_WIDTH'(ACK_TIMEOUT - 1);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = {ADDRESS_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RST_READER = 3'd1,
        S_WAIT_ADDR  = 3'd2,
        S_SETTLE     = 3'd3,
        S_PRESENT    = 3'd4,
        S_STEP       = 3'd5,
        S_DONE       = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    state_t                     state_r;
    state_t                     state_nx_s;
    logic [TIMER_WIDTH-1:0]     timer_r;
    logic [TIMER_WIDTH-1:0]     timer_nx_s;
    logic [ADDRESS_WIDTH-1:0]   expected_r;
    logic [ADDRESS_WIDTH-1:0]   expected_nx_s;
    logic [ADDRESS_WIDTH-1:0]   out_address_r;
    logic [ADDRESS_WIDTH-1:0]   out_address_nx_s;
    logic [DATA_WIDTH-1:0]      out_data_r;
    logic [DATA_WIDTH-1:0]      out_data_nx_s;

    logic reader_reset_n_r;
    logic increment_r;
    logic out_valid_r;
    logic busy_r;
    logic done_r;
    logic error_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, timer, expected-address and word-latch logic; abort wins over everything.
    always_comb begin
        state_nx_s       = state_r;
        timer_nx_s       = timer_r;
        expected_nx_s    = expected_r;
        out_address_nx_s = out_address_r;
        out_data_nx_s    = out_data_r;

        if (abort) begin
            state_nx_s = S_IDLE;
            timer_nx_s = TIMER_ZERO;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_nx_s    = S_RST_READER;
                        timer_nx_s    = TIMER_ZERO;
                        expected_nx_s = ADDR_ZERO;
                    end else begin
                        state_nx_s = state_r;
                    end
                end

                S_RST_READER: begin
                    if (timer_r == RST_LAST) begin
                        state_nx_s = S_WAIT_ADDR;
                        timer_nx_s = TIMER_ZERO;
                    end else begin
                        timer_nx_s = timer_r + TIMER_ONE;
                    end
                end

                // Only this state compares the reader's address; an early
                // arrival during STEP is simply seen here on the first cycle.
                S_WAIT_ADDR: begin
                    if (rom_address == expected_r) begin
                        state_nx_s = S_SETTLE;
                        timer_nx_s = TIMER_ZERO;
                    end else if (timer_r == ACK_LAST) begin
                        state_nx_s = S_ERROR;
                        timer_nx_s = TIMER_ZERO;
                    end else begin
                        timer_nx_s = timer_r + TIMER_ONE;
                    end
                end

                S_SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        state_nx_s       = S_PRESENT;
                        timer_nx_s       = TIMER_ZERO;
                        out_address_nx_s = expected_r;
                        out_data_nx_s    = rom_data;
                    end else begin
                        timer_nx_s = timer_r + TIMER_ONE;
                    end
                end

                // out_valid is high throughout this state, so out_ready alone
                // completes the handshake. No timeout: a stalled sink waits forever.
                S_PRESENT: begin
                    if (out_ready) begin
                        timer_nx_s = TIMER_ZERO;
                        if (expected_r == ADDR_LAST) begin
                            state_nx_s = S_DONE;
                        end else begin
                            state_nx_s    = S_STEP;
                            expected_nx_s = expected_r + ADDR_ONE;
                        end
                    end else begin
                        state_nx_s = S_PRESENT;
                    end
                end

                S_STEP: begin
                    if (timer_r == STEP_LAST) begin
                        state_nx_s = S_WAIT_ADDR;
                        timer_nx_s = TIMER_ZERO;
                    end else begin
                        timer_nx_s = timer_r + TIMER_ONE;
                    end
                end

                default: begin
                    state_nx_s = S_IDLE;
                    timer_nx_s = TIMER_ZERO;
                end
            endcase
        end
    end

    // Datapath registers: timer, expected address and the presented word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r       <= TIMER_ZERO;
            expected_r    <= ADDR_ZERO;
            out_address_r <= ADDR_ZERO;
            out_data_r    <= DATA_ZERO;
        end else begin
            timer_r       <= timer_nx_s;
            expected_r    <= expected_nx_s;
            out_address_r <= out_address_nx_s;
            out_data_r    <= out_data_nx_s;
        end
    end

    // Registered control outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reader_reset_n_r <= 1'b1;
            increment_r      <= 1'b0;
            out_valid_r      <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            error_r          <= 1'b0;
        end else begin
            reader_reset_n_r <= (state_nx_s != S_RST_READER);
            increment_r      <= (state_nx_s == S_STEP);
            out_valid_r      <= (state_nx_s == S_PRESENT);
            busy_r           <= !((state_nx_s == S_IDLE) || (state_nx_s == S_DONE) ||
                                  (state_nx_s == S_ERROR));
            done_r           <= (state_nx_s == S_DONE);
            error_r          <= (state_nx_s == S_ERROR);
        end
    end

    assign reader_reset_n    = reader_reset_n_r;
    assign increment_address = increment_r;
    assign decrement_address = 1'b0;
    assign out_valid         = out_valid_r;
    assign out_address       = out_address_r;
    assign out_data          = out_data_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed testbench for rom_dump_sequencer with a behavioural rom_reader model
// (address steps on each rising edge of increment_address, data = ~address[3:0]).

module tb_rom_dump_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] rom_address;
    logic [3:0] rom_data;
    logic       reader_reset_n;
    logic       increment_address;
    logic       decrement_address;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_address;
    logic [3:0] out_data;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    // reader model controls
    logic       stuck_en;
    logic [7:0] stuck_addr;
    logic [7:0] model_addr;
    logic       inc_q;

    // monitors
    int         inc_width  = 0;
    int         inc_pulses = 0;
    int         inc_bad    = 0;
    int         word_count = 0;
    logic [7:0] word_addr [0:4095];
    logic [3:0] word_data [0:4095];

    rom_dump_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .rom_address       (rom_address),
        .rom_data          (rom_data),
        .reader_reset_n    (reader_reset_n),
        .increment_address (increment_address),
        .decrement_address (decrement_address),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_address       (out_address),
        .out_data          (out_data),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    // rom_reader model
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_addr <= 8'h00;
            inc_q      <= 1'b0;
        end else begin
            inc_q <= increment_address;
            if (!reader_reset_n) begin
                model_addr <= 8'h00;
            end else if (increment_address && !inc_q && !(stuck_en && model_addr == stuck_addr)) begin
                model_addr <= model_addr + 8'h01;
            end
        end
    end

    assign rom_address = model_addr;
    assign rom_data    = ~model_addr[3:0];

    // increment pulse counter / width monitor
    always @(posedge clk) begin
        if (increment_address) begin
            inc_width <= inc_width + 1;
        end else begin
            if (inc_width != 0) begin
                inc_pulses <= inc_pulses + 1;
                if (inc_width != 8) inc_bad <= inc_bad + 1;
            end
            inc_width <= 0;
        end
    end

    // accepted-word capture
    always @(posedge clk) begin
        if (out_valid && out_ready && word_count < 4096) begin
            word_addr[word_count] <= out_address;
            word_data[word_count] <= out_data;
            word_count            <= word_count + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    // waits at negedges for out_valid (optionally with a given address)
    task automatic wait_word(input logic [7:0] a, input bit any_addr, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_valid && (any_addr || out_address == a)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_inc(input logic level, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (increment_address == level) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        stuck_en = 1'b0; stuck_addr = 8'h05;
        repeat (2) @(negedge clk);
        checks++;
        if ({reader_reset_n, increment_address, decrement_address, out_valid} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl got %b want 1000", {reader_reset_n, increment_address, decrement_address, out_valid});
        end
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            errors++; $display("FAIL reset_status got %b want 000", {busy, done, error});
        end
        checks++;
        if (out_address !== 8'h00 || out_data !== 4'h0) begin
            errors++; $display("FAIL reset_word got %h/%h want 00/0", out_address, out_data);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_hold busy=%b valid=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump();
        int  base_w, base_p, base_b, bad;
        bit  got;
        logic [7:0] a;
        base_w = word_count; base_p = inc_pulses; base_b = inc_bad;
        out_ready = 1'b1;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL dump_done_timeout done=%b want 1", done); end
        checks++;
        if (word_count - base_w !== 256) begin
            errors++; $display("FAIL dump_words got %0d want 256", word_count - base_w);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            if (word_addr[base_w + i] !== a || word_data[base_w + i] !== ~a[3:0]) begin
                if (bad < 4) $display("FAIL dump_word[%0d] got %h/%h want %h/%h", i,
                                      word_addr[base_w + i], word_data[base_w + i], a, ~a[3:0]);
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL dump_word_count_bad got %0d want 0", bad); end
        checks++;
        if (inc_pulses - base_p !== 255) begin
            errors++; $display("FAIL inc_pulses got %0d want 255", inc_pulses - base_p);
        end
        checks++;
        if (inc_bad - base_b !== 0) begin
            errors++; $display("FAIL inc_width_bad got %0d want 0", inc_bad - base_b);
        end
        checks++;
        if (busy !== 1'b0 || decrement_address !== 1'b0) begin
            errors++; $display("FAIL done_state busy=%b dec=%b want 0/0", busy, decrement_address);
        end
    endtask

    task automatic test_start_held();
        int base_w;
        bit got;
        base_w = word_count;
        @(negedge clk) start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL held_done_timeout done=%b want 1", done); end
        checks++;
        if (word_count - base_w !== 256) begin
            errors++; $display("FAIL held_words got %0d want 256", word_count - base_w);
        end
        @(negedge clk);
        checks++;
        if ({done, reader_reset_n, busy} !== 3'b001) begin
            errors++; $display("FAIL restart_c1 done/rrn/busy got %b want 001", {done, reader_reset_n, busy});
        end
        @(negedge clk);
        checks++;
        if (reader_reset_n !== 1'b0) begin
            errors++; $display("FAIL restart_c2 rrn got %b want 0", reader_reset_n);
        end
        @(negedge clk);
        checks++;
        if (reader_reset_n !== 1'b1) begin
            errors++; $display("FAIL restart_c3 rrn got %b want 1", reader_reset_n);
        end
        start = 1'b0;
        do_abort();
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        out_ready = 1'b1;
        pulse_start();
        wait_word(8'h10, 1'b0, 2000, ok);
        out_ready = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_reach_0x10 timeout out_address=%h want 10", out_address); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_address !== 8'h10 || out_data !== 4'hF || increment_address !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold bad_cycles=%0d valid=%b addr=%h data=%h inc=%b want 0 bad", bad,
                               out_valid, out_address, out_data, increment_address);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || increment_address !== 1'b1) begin
            errors++; $display("FAIL bp_release valid=%b inc=%b want 0/1", out_valid, increment_address);
        end
        checks++;
        if (word_addr[word_count - 1] !== 8'h10) begin
            errors++; $display("FAIL bp_accepted_addr got %h want 10", word_addr[word_count - 1]);
        end
        do_abort();
    endtask

    task automatic test_stuck_reader();
        bit ok;
        int cnt, bad;
        stuck_en = 1'b1; stuck_addr = 8'h05;
        out_ready = 1'b1;
        pulse_start();
        wait_word(8'h05, 1'b0, 1000, ok);
        @(negedge clk);
        wait_inc(1'b1, 20, ok);
        wait_inc(1'b0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stuck_step_timeout inc=%b want 0", increment_address); end
        cnt = 0;
        while (!error && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 64) begin errors++; $display("FAIL stuck_timeout_cycles got %0d want 64", cnt); end
        checks++;
        if ({error, busy} !== 2'b10) begin
            errors++; $display("FAIL stuck_status error/busy got %b want 10", {error, busy});
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || error !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stuck_quiet bad_cycles=%0d want 0", bad); end
        stuck_en = 1'b0;
        pulse_start();
        wait_word(8'h00, 1'b1, 200, ok);
        checks++;
        if (!ok || out_address !== 8'h00 || out_data !== 4'hF || error !== 1'b0) begin
            errors++; $display("FAIL stuck_relaunch ok=%b addr=%h data=%h err=%b want 1/00/f/0", ok,
                               out_address, out_data, error);
        end
        do_abort();
    endtask

    task automatic test_abort();
        bit ok;
        out_ready = 1'b1;
        pulse_start();
        wait_word(8'h80, 1'b0, 5000, ok);
        @(negedge clk);
        wait_inc(1'b1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_step_timeout inc=%b want 1", increment_address); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({increment_address, busy, out_valid, reader_reset_n} !== 4'b0001) begin
            errors++; $display("FAIL abort_outputs inc/busy/valid/rrn got %b want 0001",
                               {increment_address, busy, out_valid, reader_reset_n});
        end
        pulse_start();
        wait_word(8'h00, 1'b1, 200, ok);
        checks++;
        if (!ok || out_address !== 8'h00 || out_data !== 4'hF) begin
            errors++; $display("FAIL abort_restart ok=%b addr=%h data=%h want 1/00/f", ok, out_address, out_data);
        end
        do_abort();
    endtask

    task automatic test_async_reset();
        bit ok;
        out_ready = 1'b1;
        pulse_start();
        wait_word(8'h00, 1'b1, 200, ok);
        @(negedge clk);
        wait_inc(1'b1, 20, ok);
        wait_inc(1'b0, 20, ok);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_data !== 4'hF) begin
            errors++; $display("FAIL settle_precond busy=%b data=%h want 1/f", busy, out_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({reader_reset_n, increment_address, out_valid, busy, done, error} !== 6'b100000) begin
            errors++; $display("FAIL async_reset_ctrl got %b want 100000",
                               {reader_reset_n, increment_address, out_valid, busy, done, error});
        end
        checks++;
        if (out_address !== 8'h00 || out_data !== 4'h0) begin
            errors++; $display("FAIL async_reset_word got %h/%h want 00/0", out_address, out_data);
        end
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_start_held();
        test_backpressure();
        test_stuck_reader();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
